dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single port of the 2048-word data memory.
- Requester 0 is the CPU load/store path; requester 1 is the DMA/debug master.
- Sits between both masters and the memory.
- Issues at most one access per cycle and returns read data one cycle after grant, matching the memory's registered read.
- Round-robin fairness, with an optional bounded burst lock for requester 1.

Parameters:
AW, 11, word address width (2048 words)
DW, 32, data width
LOCK_MAX, 8, maximum consecutive locked grants to requester 1 before the lock is ignored for one arbitration

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
m0_req  input  1  CPU access request
m0_we  input  4  CPU byte write enables; bit3->[7:0], bit2->[15:8], bit1->[23:16], bit0->[31:24]; 0 = read
m0_addr  input  AW  CPU word address
m0_wdata  input  DW  CPU write data
m0_gnt  output  1  CPU request accepted this cycle (combinational)
m0_rvalid  output  1  CPU read data valid
m0_rdata  output  DW  CPU read data
m1_req, m1_we, m1_addr, m1_wdata  input  1/4/AW/DW  DMA request, same meaning as m0_*
m1_lock  input  1  DMA requests retention of grant for next cycle
m1_gnt, m1_rvalid  output  1  DMA grant / read valid
m1_rdata  output  DW  DMA read data
mem_en  output  1  memory chip enable
mem_we  output  4  memory byte write bitmap (same bit mapping)
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory registered read data

Behaviour:
- Clock/reset: one clock (clk); rst is asynchronous and active-high.
- Reset values:
  - last_gnt=1, so the CPU wins the first tie.
  - lock_cnt=0, lock_active=0.
  - rvalid tags=0; m0_rvalid=m1_rvalid=0.
- While rst is high: m*_gnt=0, mem_en=0, mem_we=0.
- Accept rule: a transfer happens when req && gnt in the same cycle.
  - A requester holds req/we/addr/wdata stable until granted.
  - req may drop without a grant; no state is left behind.
- Arbitration (combinational, from registered state):
  - Only one requester active: it is granted.
  - Both active, lock_active=1: requester 1 is granted.
  - Both active otherwise: the requester not equal to last_gnt is granted.
  - Neither active: no grant, mem_en=0.
- Memory mux:
  - mem_en = m0_gnt | m1_gnt.
  - mem_we/addr/wdata are taken from the granted requester.
  - With no grant: mem_we=0; addr/wdata are don't-care (drive 0).
- Reads/writes:
  - Every granted access sets the grantee's rvalid tag.
  - The cycle after a grant, mXX_rvalid=1 for exactly one cycle, for both reads and writes.
  - A write returns the pre-write word (read-before-write), as the memory does.
  - m0_rdata and m1_rdata both equal mem_rdata; only rvalid distinguishes the owner.
  - Back-to-back grants give back-to-back rvalid pulses.
- last_gnt updates to the grantee on every grant and holds when idle.
- Lock:
  - On an m1 grant with m1_lock=1 and lock_cnt<LOCK_MAX-1: lock_active<=1 and lock_cnt increments.
  - Otherwise (m1 grant with m1_lock=0, or the cap is reached): lock_active<=0 and lock_cnt<=0.
  - With the cap reached, the next contended cycle grants the CPU.
  - lock_active clears if m1_req is low in a cycle. An uncontended CPU grant is still allowed while lock_active=1.
  - m0_lock does not exist; the CPU never locks.
- Latency: grant at 0 cycles (same cycle); data 1 cycle.
- Reset mid-operation: all tags are cleared immediately. An rvalid for a grant issued in the cycle before reset is suppressed.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_gnt0, perf_gnt1 and perf_stall (32 bits each).
  - perf_gnt0/perf_gnt1 count grants per requester.
  - perf_stall counts cycles where a requester had req=1 and gnt=0; both stalled in the same cycle is impossible.
  - All counters reset to 0 on rst and wrap modulo 2^32.
- Undefined: the ports and counters are absent; arbitration behaviour is identical.

Test Plan:
- Single requester: m0 read addr 0x005 (mem preloaded 0xDEADBEEF) -> m0_gnt=1 same cycle, mem_en=1, mem_addr=0x005; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- Contention: both request continuously from reset -> grants alternate m0,m1,m0,m1; rvalid pulses follow each grant by one cycle.
- Byte write via m1: m1_we=4'b1000, wdata=0x000000AA to addr 0x010 holding 0x11223344 -> later m0 read returns 0x112233AA.
- Lock cap: LOCK_MAX=8, m1_lock=1 and both requesting -> m1 granted 8 consecutive cycles, then m0 granted once, then m1 resumes.
- Reset mid-burst: assert rst the cycle after an m0 grant -> m0_rvalid stays 0, mem_en=0 during reset; first grant after release goes to m0 on contention.
- With DMEM_ARB_PERF_EN: 10 contended cycles without lock -> perf_gnt0=5, perf_gnt1=5, perf_stall=10.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, DMA and memory-side signal bundle for dmem_arbiter.
// Perf counter signals exist only when DMEM_ARB_PERF_EN is defined.
interface dmem_arbiter_if #(
    parameter int AW = 11,
    parameter int DW = 32
);
    logic          m0_req;
    logic [3:0]    m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req;
    logic [3:0]    m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_lock;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]   perf_gnt0;
    logic [31:0]   perf_gnt1;
    logic [31:0]   perf_stall;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output perf_gnt0, perf_gnt1, perf_stall
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  perf_gnt0, perf_gnt1, perf_stall
    );
`else
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
`endif
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin CPU/DMA arbiter for the single data memory port.
// Define DMEM_ARB_PERF_EN to add grant and stall performance counters.
module dmem_arbiter #(
    parameter int AW       = 11,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 8
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    localparam int CW = $clog2(LOCK_MAX) + 1;

    logic          r_last_gnt;
    logic          r_lock_active;
    logic [CW-1:0] r_lock_cnt;
    logic          r_tag0;
    logic          r_tag1;
    logic          w_both;
    logic          w_pick1;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_lock_go;

    // Grant from registered history: a held lock or an m0 last grant favours m1 on contention
    always_comb begin
        w_both    = bus.m0_req && bus.m1_req;
        w_pick1   = r_lock_active || !r_last_gnt;
        w_gnt0    = !rst && bus.m0_req && !(w_both && w_pick1);
        w_gnt1    = !rst && bus.m1_req && !(w_both && !w_pick1);
        w_lock_go = bus.m1_lock && (r_lock_cnt < CW'(LOCK_MAX - 1));
    end

    assign bus.m0_gnt    = w_gnt0;
    assign bus.m1_gnt    = w_gnt1;
    assign bus.mem_en    = w_gnt0 || w_gnt1;
    assign bus.mem_we    = w_gnt0 ? bus.m0_we : w_gnt1 ? bus.m1_we : 4'b0;
    assign bus.mem_addr  = w_gnt0 ? bus.m0_addr : w_gnt1 ? bus.m1_addr : {AW{1'b0}};
    assign bus.mem_wdata = w_gnt0 ? bus.m0_wdata : w_gnt1 ? bus.m1_wdata : {DW{1'b0}};
    assign bus.m0_rvalid = r_tag0;
    assign bus.m1_rvalid = r_tag1;
    assign bus.m0_rdata  = bus.mem_rdata;
    assign bus.m1_rdata  = bus.mem_rdata;

    // Track round-robin winner, DMA lock streak and the one-cycle read-valid tags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_gnt    <= 1'b1;
            r_lock_active <= 1'b0;
            r_lock_cnt    <= '0;
            r_tag0        <= 1'b0;
            r_tag1        <= 1'b0;
        end else begin
            r_tag0 <= w_gnt0;
            r_tag1 <= w_gnt1;
            if (w_gnt0 || w_gnt1)
                r_last_gnt <= w_gnt1;
            if (!bus.m1_req || (w_gnt1 && !w_lock_go)) begin
                r_lock_active <= 1'b0;
                r_lock_cnt    <= '0;
            end else if (w_gnt1) begin
                r_lock_active <= 1'b1;
                r_lock_cnt    <= r_lock_cnt + CW'(1);
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] r_perf_gnt0;
    logic [31:0] r_perf_gnt1;
    logic [31:0] r_perf_stall;

    // Free-running grant and stall counters, wrapping naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_gnt0  <= '0;
            r_perf_gnt1  <= '0;
            r_perf_stall <= '0;
        end else begin
            r_perf_gnt0  <= r_perf_gnt0 + 32'(w_gnt0);
            r_perf_gnt1  <= r_perf_gnt1 + 32'(w_gnt1);
            r_perf_stall <= r_perf_stall + 32'((bus.m0_req && !w_gnt0) || (bus.m1_req && !w_gnt1));
        end
    end

    assign bus.perf_gnt0  = r_perf_gnt0;
    assign bus.perf_gnt1  = r_perf_gnt1;
    assign bus.perf_stall = r_perf_stall;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench with a behavioural memory and arbitration model.
module tb_dmem_arbiter;
    localparam int LOCK_MAX = 8;

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    logic [31:0] mem [2048];
    logic [31:0] ref_mem [2048];
    bit          mem_ready;
    bit          pend [2];
    logic [3:0]  rq_we [2];
    logic [10:0] rq_addr [2];
    logic [31:0] rq_wd [2];
    bit          lk;
    int          drop_pct = 0;
    int          m_last = 1;
    bit          m_locked = 1'b0;
    int          m_streak = 0;
    logic [31:0] p_g0 = 0;
    logic [31:0] p_g1 = 0;
    logic [31:0] p_st = 0;

    dmem_arbiter_if #(.AW(11), .DW(32)) bus ();

    dmem_arbiter #(.AW(11), .DW(32), .LOCK_MAX(LOCK_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(int k);
        if (k == 5) return 32'hDEADBEEF;
        if (k == 16) return 32'h11223344;
        return 32'(k) * 32'h9E3779B1 ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp_v, $time);
        end
    endfunction

    // Environment memory: registered read, byte-lane write, read-before-write
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < 2048; k++) mem[k] <= init_val(k);
            mem_ready <= 1'b1;
        end else if (bus.mem_en) begin
            bus.mem_rdata <= mem[bus.mem_addr];
            for (int k = 0; k < 4; k++)
                if (bus.mem_we[3-k]) mem[bus.mem_addr][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
        end
    end

    // Monitor: every rvalid pulse must match the oldest outstanding grant
    always @(negedge clk) begin
        if (bus.m0_rvalid || bus.m1_rvalid || q.size() > 0) begin
            if (q.size() == 0) begin
                cmp("rvalid_unexpected", {30'b0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                cmp("rvalid_owner", {30'b0, bus.m1_rvalid, bus.m0_rvalid}, (e.id == 1) ? 32'd2 : 32'd1);
                cmp("rdata", (e.id == 1) ? bus.m1_rdata : bus.m0_rdata, e.data);
            end
        end
    end

    task automatic new_req(input int i);
        pend[i]    = 1'b1;
        rq_we[i]   = ($urandom_range(1) == 0) ? 4'b0 : 4'($urandom_range(15));
        rq_addr[i] = 11'($urandom_range(31));
        rq_wd[i]   = $urandom;
    endtask

    task automatic set_req(input int i, input logic [3:0] we, input logic [10:0] addr, input logic [31:0] wd);
        pend[i]    = 1'b1;
        rq_we[i]   = we;
        rq_addr[i] = addr;
        rq_wd[i]   = wd;
    endtask

    task automatic drive();
        bus.m0_req   = pend[0];
        bus.m0_we    = rq_we[0];
        bus.m0_addr  = rq_addr[0];
        bus.m0_wdata = rq_wd[0];
        bus.m1_req   = pend[1];
        bus.m1_we    = rq_we[1];
        bus.m1_addr  = rq_addr[1];
        bus.m1_wdata = rq_wd[1];
        bus.m1_lock  = lk;
    endtask

    // Reference model of one arbitration cycle; also pushes the expected response
    task automatic model_check();
        bit both, e0, e1, q0, q1;
        int k;
        q0   = pend[0];
        q1   = pend[1];
        both = q0 && q1;
        e1   = q1 && (!both || m_locked || m_last == 0);
        e0   = q0 && !e1;
        cmp("m0_gnt", 32'(bus.m0_gnt), 32'(e0));
        cmp("m1_gnt", 32'(bus.m1_gnt), 32'(e1));
        cmp("mem_en", 32'(bus.mem_en), 32'(e0 || e1));
`ifdef DMEM_ARB_PERF_EN
        cmp("perf_gnt0", bus.perf_gnt0, p_g0);
        cmp("perf_gnt1", bus.perf_gnt1, p_g1);
        cmp("perf_stall", bus.perf_stall, p_st);
`endif
        p_g0 += 32'(e0);
        p_g1 += 32'(e1);
        p_st += 32'((q0 && !e0) || (q1 && !e1));
        if (e0 || e1) begin
            k = e1 ? 1 : 0;
            cmp("mem_addr", 32'(bus.mem_addr), 32'(rq_addr[k]));
            cmp("mem_we", 32'(bus.mem_we), 32'(rq_we[k]));
            cmp("mem_wdata", bus.mem_wdata, rq_wd[k]);
            q.push_back('{id: k, data: ref_mem[rq_addr[k]]});
            for (int b = 0; b < 4; b++)
                if (rq_we[k][3-b]) ref_mem[rq_addr[k]][8*b +: 8] = rq_wd[k][8*b +: 8];
            pend[k] = 1'b0;
            m_last  = k;
        end else begin
            cmp("mem_we_idle", 32'(bus.mem_we), 32'd0);
        end
        if (!q1 || (e1 && !(lk && m_streak < LOCK_MAX - 1))) begin
            m_locked = 1'b0;
            m_streak = 0;
        end else if (e1) begin
            m_locked = 1'b1;
            m_streak++;
        end
    endtask

    task automatic step(input int p0, input int p1, input int pl);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (pend[i] && int'($urandom_range(99)) < drop_pct) pend[i] = 1'b0;
            if (!pend[i] && int'($urandom_range(99)) < ((i == 0) ? p0 : p1)) new_req(i);
        end
        lk = int'($urandom_range(99)) < pl;
        drive();
        #1 model_check();
    endtask

    // Reset mid-operation with both requesters asserting, then release between edges
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        m_last   = 1;
        m_locked = 1'b0;
        m_streak = 0;
        p_g0 = 0;
        p_g1 = 0;
        p_st = 0;
        for (int i = 0; i < 2; i++) if (!pend[i]) new_req(i);
        drive();
        #1;
        cmp("rst_m0_gnt", 32'(bus.m0_gnt), 32'd0);
        cmp("rst_m1_gnt", 32'(bus.m1_gnt), 32'd0);
        cmp("rst_mem_en", 32'(bus.mem_en), 32'd0);
        cmp("rst_mem_we", 32'(bus.mem_we), 32'd0);
        cmp("rst_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
        cmp("rst_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2048; k++) ref_mem[k] = init_val(k);
        lk = 1'b0;
        new_req(0);
        new_req(1);
        drive();
        @(posedge clk);
        #1;
        cmp("init_m0_gnt", 32'(bus.m0_gnt), 32'd0);
        cmp("init_m1_gnt", 32'(bus.m1_gnt), 32'd0);
        cmp("init_mem_en", 32'(bus.mem_en), 32'd0);
        cmp("init_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
        cmp("init_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        pend[1] = 1'b0;
        set_req(0, 4'b0, 11'h005, 32'h0);
        step(0, 0, 0);
        cmp("single_gnt", 32'(bus.m0_gnt), 32'd1);
        cmp("single_addr", 32'(bus.mem_addr), 32'h005);
        step(0, 0, 0);
        cmp("single_rvalid", 32'(bus.m0_rvalid), 32'd1);
        cmp("single_rdata", bus.m0_rdata, 32'hDEADBEEF);
        cmp("single_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);

        set_req(1, 4'b1000, 11'h010, 32'h0000_00AA);
        step(0, 0, 0);
        set_req(0, 4'b0, 11'h010, 32'h0);
        step(0, 0, 0);
        step(0, 0, 0);
        cmp("bytewr_rvalid", 32'(bus.m0_rvalid), 32'd1);
        cmp("bytewr_rdata", bus.m0_rdata, 32'h112233AA);

        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(100, 100, 0);
            cmp("alternate_m0", 32'(bus.m0_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(100, 100, 100);
            cmp("lock_seq_m1", 32'(bus.m1_gnt), (i == 0 || i == 9 || i == 18) ? 32'd0 : 32'd1);
        end

        pend[1] = 1'b0;
        set_req(0, 4'b0, 11'h007, 32'h0);
        step(0, 0, 0);
        do_reset();
        cmp("rst_burst_rvalid", 32'(bus.m0_rvalid), 32'd0);
        step(100, 100, 0);
        cmp("rst_first_m0", 32'(bus.m0_gnt), 32'd1);

        do_reset();
        for (int i = 0; i < 10; i++) step(100, 100, 0);
        step(0, 0, 0);
`ifdef DMEM_ARB_PERF_EN
        cmp("perf10_gnt0", bus.perf_gnt0, 32'd5);
        cmp("perf10_gnt1", bus.perf_gnt1, 32'd5);
        cmp("perf10_stall", bus.perf_stall, 32'd10);
`endif

        drop_pct = 10;
        for (int n = 0; n < 2000; n++) begin
            if (n % 400 == 399) do_reset();
            step(int'($urandom_range(100)), int'($urandom_range(100)), int'($urandom_range(100)));
        end
        drop_pct = 0;
        for (int n = 0; n < 5; n++) step(0, 0, 0);
        cmp("drain_queue", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
